package_mode_ctrl: RTL

Sequencer for the packager's self-test datapath select. It owns the `rf_self_test_mode` select line feeding the ADC/packet-generator input mux, and only switches that mux at packet boundaries so the packager never sees a mixed packet. It also starts and stops the packet generator, counts generated packets against a programmed limit, and reports status back to the register file.

---
 rtl/package_mode_ctrl_pkg.sv | 14 +
 rtl/package_mode_ctrl_if.sv | 28 ++
 rtl/package_mode_ctrl_drain_timer.sv | 25 ++
 rtl/package_mode_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/package_mode_ctrl_pkg.sv
// Shared types for the packager self-test mode sequencer.
package pkt_ctrl_pkg;

  localparam int PKT_CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_ADC,
    ST_DRAIN_A,
    ST_GEN_START,
    ST_GEN_RUN,
    ST_DRAIN_G
  } state_e;

endpackage

// File: rtl/package_mode_ctrl_if.sv
// Register-file / packager / generator signals of package_mode_ctrl.
interface package_mode_ctrl_if #(
  parameter int PKT_CNT_W = pkt_ctrl_pkg::PKT_CNT_W_DEFAULT
);
  logic                 rf_self_test_en;
  logic [PKT_CNT_W-1:0] rf_test_pkt_num;
  logic                 pkt_busy;
  logic                 pkt_gen_done;
  logic                 rf_self_test_mode;
  logic                 pkt_gen_start;
  logic                 pkt_gen_stop;
  logic                 test_active;
  logic [PKT_CNT_W-1:0] test_pkt_cnt;
  logic                 test_done;
  logic                 drain_timeout_err;

  modport master (
    output rf_self_test_en, rf_test_pkt_num, pkt_busy, pkt_gen_done,
    input  rf_self_test_mode, pkt_gen_start, pkt_gen_stop, test_active,
           test_pkt_cnt, test_done, drain_timeout_err
  );

  modport slave (
    input  rf_self_test_en, rf_test_pkt_num, pkt_busy, pkt_gen_done,
    output rf_self_test_mode, pkt_gen_start, pkt_gen_stop, test_active,
           test_pkt_cnt, test_done, drain_timeout_err
  );
endinterface

// File: rtl/package_mode_ctrl_drain_timer.sv
// Drain watchdog: fires after LIMIT busy cycles spent in a drain state.
module pkt_drain_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arm,
  input  logic i_busy,
  output logic o_fire
);
  localparam int            TW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [TW-1:0] LOAD = TW'(LIMIT - 1);

  logic [TW-1:0] r_cnt;

  // Reloads whenever the FSM is outside a drain state, so every drain visit starts fresh.
  always_ff @(posedge clk) begin
    if (rst || !i_arm)
      r_cnt <= LOAD;
    else if (i_busy && r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_fire = i_arm && i_busy && (r_cnt == '0);
endmodule

// File: rtl/package_mode_ctrl.sv
// Self-test mux sequencer; switches only at packet boundaries.
// Drain watchdog enabled by PACKAGE_MODE_CTRL_TIMEOUT_EN.
//
// state        | meaning
// ST_ADC       | mux on ADC, idle
// ST_DRAIN_A   | self-test requested, waiting for packager idle
// ST_GEN_START | mux on generator, start pulse, count cleared
// ST_GEN_RUN   | counting generated packets against the limit
// ST_DRAIN_G   | generator stopped, waiting for packager idle
module package_mode_ctrl
  import pkt_ctrl_pkg::*;
#(
  parameter int PKT_CNT_W     = PKT_CNT_W_DEFAULT,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  package_mode_ctrl_if.slave  bus
);
  localparam logic [PKT_CNT_W-1:0] CNT_MAX = '1;

  state_e               r_state;
  logic                 r_mode, r_start, r_stop, r_active, r_done, r_err;
  logic [PKT_CNT_W-1:0] r_cnt;
  logic [PKT_CNT_W-1:0] w_cnt_inc;
  logic                 w_limit_hit, w_fire, w_idle;

  assign w_cnt_inc   = (bus.pkt_gen_done && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
  // Compare against the post-increment count so a done landing on the limit exits at once.
  assign w_limit_hit = (bus.rf_test_pkt_num != '0) && (w_cnt_inc >= bus.rf_test_pkt_num);

`ifdef PACKAGE_MODE_CTRL_TIMEOUT_EN
  logic w_drain;
  assign w_drain = (r_state == ST_DRAIN_A) || (r_state == ST_DRAIN_G);

  pkt_drain_timer #(.LIMIT(DRAIN_TIMEOUT)) u_drain_timer (
    .clk    (clk),
    .rst    (rst),
    .i_arm  (w_drain),
    .i_busy (bus.pkt_busy),
    .o_fire (w_fire)
  );
`else
  assign w_fire = 1'b0;
`endif

  assign w_idle = !bus.pkt_busy || w_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ADC;
      r_mode   <= 1'b0;
      r_start  <= 1'b0;
      r_stop   <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_ADC: begin
          if (bus.rf_self_test_en) r_state <= ST_DRAIN_A;
        end
        ST_DRAIN_A: begin
          if (!bus.rf_self_test_en) begin
            r_state <= ST_ADC;
          end else if (w_idle) begin
            r_state  <= ST_GEN_START;
            r_mode   <= 1'b1;
            r_active <= 1'b1;
            r_start  <= 1'b1;
            r_cnt    <= '0;
            if (w_fire) r_err <= 1'b1;
          end
        end
        ST_GEN_START: begin
          r_state <= ST_GEN_RUN;
        end
        ST_GEN_RUN: begin
          r_cnt <= w_cnt_inc;
          if (!bus.rf_self_test_en || w_limit_hit) begin
            r_state <= ST_DRAIN_G;
            r_stop  <= 1'b1;
          end
        end
        ST_DRAIN_G: begin
          r_cnt <= w_cnt_inc;
          if (w_idle) begin
            r_state  <= ST_ADC;
            r_mode   <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b1;
            if (w_fire) r_err <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_ADC;
          r_mode   <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rf_self_test_mode = r_mode;
  assign bus.pkt_gen_start     = r_start;
  assign bus.pkt_gen_stop      = r_stop;
  assign bus.test_active       = r_active;
  assign bus.test_pkt_cnt      = r_cnt;
  assign bus.test_done         = r_done;
  assign bus.drain_timeout_err = r_err;
endmodule
